prog_mem_arbiter: RTL and testbench
===================================

Name: prog_mem_arbiter

Overview:
- Owns the 16x4 program nibble memory used by the 4-bit CPU and shares its single access port between three requesters, one access per cycle:
  - the assembler loader, which writes program nibbles;
  - the CPU fetch unit, which reads an 8-bit instruction as {mem[a+1], mem[a]};
  - a debug read port.
- The loader has absolute priority. Fetch and debug reads are arbitrated round-robin.
- While loading is active, the block stalls the CPU through cpu_hold.

Parameters:
- AW, 4, address width; memory depth is 2**AW.
- DW, 4, nibble width; f_instr is 2*DW.
- CLR_ON_RST, 1, when 1 the memory array is cleared to 0 on reset; when 0, memory contents are untouched by reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ld_req  in  1  loader write request.
- ld_addr  in  AW  loader write address.
- ld_data  in  DW  loader write nibble.
- ld_ack  out  1  one-cycle pulse: write done.
- f_req  in  1  CPU fetch request.
- f_addr  in  AW  fetch address (PC).
- f_ack  out  1  one-cycle pulse: f_instr valid.
- f_instr  out  2*DW  {mem[f_addr+1], mem[f_addr]}.
- d_req  in  1  debug read request.
- d_addr  in  AW  debug read address.
- d_ack  out  1  one-cycle pulse: d_data valid.
- d_data  out  DW  mem[d_addr].
- busy  out  1  high when state != IDLE.
- cpu_hold  out  1  combinational: ld_req | (state==RESP & owner==LD).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, owner=NONE, rr_last=DBG so fetch wins first.
  - ld_ack=f_ack=d_ack=0, f_instr=0, d_data=0, busy=0.
  - Memory is cleared to 0 when CLR_ON_RST=1.
- FSM states: IDLE, FLO, FHI, DRD, RESP. Requests are sampled only in IDLE. Addresses and data are latched at the grant edge, so requesters may change them afterwards.
- Grant in IDLE, at edge E0:
  - If ld_req: owner=LD, mem[ld_addr]<=ld_data at E0, go to RESP.
  - Else if f_req and d_req both high: grant the one that is not rr_last.
  - Else: grant whichever of f_req/d_req is high.
  - rr_last updates only on fetch or debug grants; loader grants never change it.
- Fetch: E0 IDLE->FLO, latch a=f_addr. E1 capture lo=mem[a], go to FHI. E2 capture hi=mem[(a+1) mod 2**AW], register f_instr={hi,lo}, go to RESP.
- Debug: E0 IDLE->DRD, latch d_addr. E1 register d_data=mem[addr], go to RESP.
- RESP: the owner's ack is high for exactly this one cycle. The next edge returns to IDLE. Requests are not sampled in RESP.
- Latency from sampling edge to ack high:
  - load: ack after E0 (1 cycle);
  - debug: ack after E1 (2 cycles);
  - fetch: ack after E2 (3 cycles).
- Throughput, per transaction including RESP:
  - load: 1 per 2 cycles;
  - debug: 1 per 3 cycles;
  - fetch: 1 per 4 cycles.
- Handshake:
  - A requester holds req until its ack.
  - If req is still high in the IDLE cycle after ack, that is a new transaction using the then-current addr/data.
  - Dropping req before grant cancels the request with no side effect.
- Non-preemption: an in-flight fetch or debug read always completes. A loader request arriving during one is served at the next IDLE. A fetch spanning a write therefore returns pre-write data for any nibble already captured.
- Wrap-around: a fetch at a=2**AW-1 reads hi from address 0.
- Starvation: a continuously held ld_req starves fetch and debug by design, and cpu_hold stays 1 throughout.
- Reset asserted mid-transaction:
  - the transaction is abandoned and no ack is issued;
  - a load write that already happened at E0 persists when CLR_ON_RST=0.
- Only one ack can be high in any cycle. Acks never assert outside RESP.
- Accesses are modelled as register captures. There is no combinational path from memory to the outputs.

Test Plan:
- Load 0x1→@0, 0x2→@1, 0xF→@15, each held until ld_ack → each ld_ack is 1 cycle wide. Then d_req @1 → d_data=0x2 with d_ack 2 cycles after sampling.
- After the above: f_req a=0 → f_instr=0x21, f_ack 3 cycles after the sampling edge; f_req a=15 → f_instr=0x1F (wrap to @0).
- f_req and d_req raised on the same edge, both held → fetch acked first, then debug. Repeat the simultaneous raise → debug is served first (round-robin alternates).
- ld_req (@1←0x9) raised one cycle into a fetch of a=0 → fetch completes with f_instr=0x21. ld_ack follows in the next IDLE; cpu_hold=1 from ld_req rise through the ld_ack cycle. Refetch a=0 → 0x91.
- Hold ld_req continuously for 10 cycles with f_req high → no f_ack, cpu_hold=1, and ld_ack fires every 2 cycles. Drop ld_req → f_ack within 4 cycles.
- Assert reset during FHI of a fetch (CLR_ON_RST=1) → f_ack never pulses, all outputs are 0, and after release d_req @0 returns 0x0.

Source files
------------

// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter: owns the 2**AW x DW program nibble memory and shares its
// single access port between the loader (absolute priority), the CPU fetch
// unit (two-nibble reads) and a debug read port (round-robin with fetch).
// Every memory read lands in a register; no output has a combinational path
// from the array.
module prog_mem_arbiter #(
  parameter int AW         = 4,
  parameter int DW         = 4,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_req,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_data,
  output logic            ld_ack,
  input  logic            f_req,
  input  logic [AW-1:0]   f_addr,
  output logic            f_ack,
  output logic [2*DW-1:0] f_instr,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  output logic            d_ack,
  output logic [DW-1:0]   d_data,
  output logic            busy,
  output logic            cpu_hold
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {IDLE, FLO, FHI, DRD, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_FE, OWN_DB} owner_t;

  // Context of the read in flight: address latched at grant, low nibble of a fetch.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] lo;
  } rd_ctx_t;

  state_t  state, state_nx;
  owner_t  owner, owner_nx;
  logic    rr_last_db, rr_last_db_nx;   // 1: last fetch/debug grant went to debug
  rd_ctx_t ctx;
  logic [AW-1:0] addr_nx;
  logic    mem_we;

  logic [DEPTH-1:0][DW-1:0] mem;

  // Arbitration and sequencing; requests are only looked at in IDLE.
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    rr_last_db_nx = rr_last_db;
    addr_nx       = ctx.addr;
    mem_we        = 1'b0;
    case (state)
      IDLE: begin
        if (ld_req) begin
          owner_nx = OWN_LD;
          mem_we   = 1'b1;
          state_nx = RESP;
        end else if (f_req && (!d_req || rr_last_db)) begin
          owner_nx      = OWN_FE;
          addr_nx       = f_addr;
          rr_last_db_nx = 1'b0;
          state_nx      = FLO;
        end else if (d_req) begin
          owner_nx      = OWN_DB;
          addr_nx       = d_addr;
          rr_last_db_nx = 1'b1;
          state_nx      = DRD;
        end
      end
      FLO:     state_nx = FHI;
      FHI:     state_nx = RESP;
      DRD:     state_nx = RESP;
      RESP: begin
        owner_nx = OWN_NONE;
        state_nx = IDLE;
      end
      default: begin
        owner_nx = OWN_NONE;
        state_nx = IDLE;
      end
    endcase
  end

  // Control state; rr_last resets to debug so fetch wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      rr_last_db <= 1'b1;
      ctx.addr   <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      rr_last_db <= rr_last_db_nx;
      ctx.addr   <= addr_nx;
    end
  end

  // Read captures: low nibble in FLO, full instruction in FHI, debug nibble in DRD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctx.lo  <= '0;
      f_instr <= '0;
      d_data  <= '0;
    end else begin
      if (state == FLO) ctx.lo  <= mem[ctx.addr];
      if (state == FHI) f_instr <= {mem[ctx.addr + AW'(1)], ctx.lo};
      if (state == DRD) d_data  <= mem[ctx.addr];
    end
  end

  // Storage array; the reset-clear variant is selected by CLR_ON_RST.
  generate
    if (CLR_ON_RST) begin : g_mem_clr
      // Loader write at the grant edge, array cleared on reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)      mem <= '0;
        else if (mem_we) mem[ld_addr] <= ld_data;
      end
    end else begin : g_mem_keep
      // Loader write at the grant edge; reset leaves contents alone.
      always_ff @(posedge clk) begin
        if (reset && mem_we) mem[ld_addr] <= ld_data;
      end
    end
  endgenerate

  // Acks are decoded from registered state only, so at most one is high.
  assign ld_ack   = (state == RESP) && (owner == OWN_LD);
  assign f_ack    = (state == RESP) && (owner == OWN_FE);
  assign d_ack    = (state == RESP) && (owner == OWN_DB);
  assign busy     = (state != IDLE);
  assign cpu_hold = ld_req | ld_ack;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter: loads, fetch/debug latency, wrap,
// round-robin, load-during-fetch, loader starvation and mid-fetch reset.
module tb_prog_mem_arbiter;

  logic       clk, reset;
  logic       ld_req, f_req, d_req;
  logic [3:0] ld_addr, ld_data, f_addr, d_addr;
  logic       ld_ack, f_ack, d_ack, busy, cpu_hold;
  logic [7:0] f_instr;
  logic [3:0] d_data;

  int total = 0;
  int bad   = 0;
  int n, fc, dc;

  prog_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_instr(f_instr),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_data(d_data),
    .busy(busy), .cpu_hold(cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int sel);
    return (sel == 0) ? ld_ack : (sel == 1) ? f_ack : d_ack;
  endfunction

  // Ticks until the selected ack is seen or max cycles pass; n = cycles taken.
  task automatic wait_ack(input string tag, input int sel, input int max, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!ack_of(sel) && cyc < max);
    chk({tag, "_ack_seen"}, {31'b0, ack_of(sel)}, 1);
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] d, output int cyc);
    ld_req = 1'b1; ld_addr = a; ld_data = d;
    wait_ack("ld", 0, 4, cyc);
    chk("ld_hold_in_ack", {31'b0, cpu_hold}, 1);
    ld_req = 1'b0;
    tick();
    chk("ld_ack_width", {31'b0, ld_ack}, 0);
  endtask

  task automatic do_fetch(input logic [3:0] a, output int cyc);
    f_req = 1'b1; f_addr = a;
    wait_ack("f", 1, 8, cyc);
    f_req = 1'b0;
    tick();
    chk("f_ack_width", {31'b0, f_ack}, 0);
  endtask

  task automatic do_dbg(input logic [3:0] a, output int cyc);
    d_req = 1'b1; d_addr = a;
    wait_ack("d", 2, 8, cyc);
    d_req = 1'b0;
    tick();
    chk("d_ack_width", {31'b0, d_ack}, 0);
  endtask

  // Raise fetch(a=0) and debug(@15) together; record the cycle of each ack.
  task automatic pair(output int fcyc, output int dcyc);
    f_req = 1'b1; f_addr = 4'd0; d_req = 1'b1; d_addr = 4'd15;
    fcyc = 0; dcyc = 0;
    for (int c = 1; c <= 12 && (fcyc == 0 || dcyc == 0); c++) begin
      tick();
      chk("ack_excl", {31'b0, f_ack & d_ack}, 0);
      if (f_ack) begin fcyc = c; f_req = 1'b0; end
      if (d_ack) begin dcyc = c; d_req = 1'b0; end
    end
    tick();
    chk("pair_f_instr", {24'b0, f_instr}, 32'h21);
    chk("pair_d_data", {28'b0, d_data}, 32'hF);
  endtask

  initial begin
    reset = 1'b1;
    ld_req = 0; f_req = 0; d_req = 0;
    ld_addr = 0; ld_data = 0; f_addr = 0; d_addr = 0;
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_acks", {29'b0, ld_ack, f_ack, d_ack}, 0);
    chk("rst_f_instr", {24'b0, f_instr}, 0);
    chk("rst_d_data", {28'b0, d_data}, 0);
    reset = 1'b1;
    tick();

    // Loads: one-cycle latency, one-cycle ack
    do_load(4'd0, 4'h1, n);  chk("ld0_lat", n, 1);
    do_load(4'd1, 4'h2, n);  chk("ld1_lat", n, 1);
    do_load(4'd15, 4'hF, n); chk("ld15_lat", n, 1);
    chk("idle_hold", {31'b0, cpu_hold}, 0);

    // Debug and fetch reads
    do_dbg(4'd1, n);   chk("d1_lat", n, 2); chk("d1_data", {28'b0, d_data}, 32'h2);
    do_fetch(4'd0, n); chk("f0_lat", n, 3); chk("f0_instr", {24'b0, f_instr}, 32'h21);
    do_fetch(4'd15, n); chk("f15_lat", n, 3); chk("f15_wrap", {24'b0, f_instr}, 32'h1F);

    // Round-robin: lone debug leaves rr_last=debug, so fetch wins the tie
    do_dbg(4'd15, n);  chk("d15_data", {28'b0, d_data}, 32'hF);
    pair(fc, dc);
    chk("rr1_f_cyc", fc, 3); chk("rr1_d_cyc", dc, 6);
    // Lone fetch leaves rr_last=fetch, so debug wins the next tie
    do_fetch(4'd0, n);
    pair(fc, dc);
    chk("rr2_d_cyc", dc, 2); chk("rr2_f_cyc", fc, 6);

    // Loader request arriving one cycle into a fetch waits for it
    f_req = 1'b1; f_addr = 4'd0;
    tick();
    chk("lf_busy", {31'b0, busy}, 1);
    ld_req = 1'b1; ld_addr = 4'd1; ld_data = 4'h9;
    #1 chk("lf_hold_rise", {31'b0, cpu_hold}, 1);
    tick();
    chk("lf_hold_fhi", {31'b0, cpu_hold}, 1);
    chk("lf_no_ldack", {31'b0, ld_ack}, 0);
    tick();
    chk("lf_f_ack", {31'b0, f_ack}, 1);
    chk("lf_f_instr", {24'b0, f_instr}, 32'h21);
    chk("lf_hold_resp", {31'b0, cpu_hold}, 1);
    f_req = 1'b0;
    tick();
    chk("lf_idle_ldack", {31'b0, ld_ack}, 0);
    chk("lf_hold_idle", {31'b0, cpu_hold}, 1);
    tick();
    chk("lf_ld_ack", {31'b0, ld_ack}, 1);
    ld_req = 1'b0;
    #1 chk("lf_hold_ack", {31'b0, cpu_hold}, 1);
    tick();
    chk("lf_hold_end", {31'b0, cpu_hold}, 0);
    do_fetch(4'd0, n); chk("lf_refetch", {24'b0, f_instr}, 32'h91);

    // Continuously held loader starves fetch
    ld_req = 1'b1; ld_addr = 4'd2; ld_data = 4'h5;
    f_req = 1'b1; f_addr = 4'd0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("starve_f_ack", {31'b0, f_ack}, 0);
      chk("starve_hold", {31'b0, cpu_hold}, 1);
      chk("starve_ld_ack", {31'b0, ld_ack}, {31'b0, (i % 2) == 1});
    end
    ld_req = 1'b0;
    wait_ack("starve_f", 1, 4, n);
    chk("starve_f_instr", {24'b0, f_instr}, 32'h91);
    f_req = 1'b0;
    tick();

    // Reset during FHI abandons the fetch and clears everything
    f_req = 1'b1; f_addr = 4'd0;
    tick(); tick();
    chk("rf_busy", {31'b0, busy}, 1);
    reset = 1'b0;
    #1;
    chk("rf_busy0", {31'b0, busy}, 0);
    chk("rf_acks0", {29'b0, ld_ack, f_ack, d_ack}, 0);
    chk("rf_f_instr0", {24'b0, f_instr}, 0);
    chk("rf_d_data0", {28'b0, d_data}, 0);
    chk("rf_hold0", {31'b0, cpu_hold}, 0);
    f_req = 1'b0;
    tick(); chk("rf_no_fack_a", {31'b0, f_ack}, 0);
    tick(); chk("rf_no_fack_b", {31'b0, f_ack}, 0);
    reset = 1'b1;
    tick(); chk("rf_no_fack_c", {31'b0, f_ack}, 0);
    do_dbg(4'd0, n); chk("rf_d0_lat", n, 2); chk("rf_d0_clr", {28'b0, d_data}, 0);
    do_dbg(4'd1, n); chk("rf_d1_clr", {28'b0, d_data}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
